pll_md_responder: RTL and testbench

//  Responder (target) side of the PLL management-data (MD) port driven by the PLL init sequencer.

---
 rtl/pll_md_responder.sv | 137 +++++++++++++
 tb/tb_pll_md_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_md_responder.sv
// Responder side of the PLL management-data port: byte-wide config register file plus relock emulation.
// Optional feature macro PLL_MD_ADDR_WRAP_EN: mdainc at the last mapped address wraps to 0 instead of saturating.
module pll_md_responder #(
  parameter int         DEPTH       = 16,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] MULTI_FAC   = 8'd16,
  parameter logic [7:0] DIV0_RST    = 8'd4,
  parameter logic [7:0] DIV2_RST    = 8'd8,
  parameter int         LOCK_CYCLES = 64
) (
  input  logic       mdclk,
  input  logic       reset_n,
  input  logic [1:0] mdopc,
  input  logic       mdainc,
  input  logic [7:0] mdwdi,
  output logic [7:0] mdrdo,
  output logic       lock,
  output logic [7:0] fbdiv,
  output logic [7:0] div0,
  output logic [7:0] div2,
  output logic       cfg_update,
  output logic       md_err
);
  localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CW   = $clog2(LOCK_CYCLES + 1);
  localparam logic [7:0] LAST = 8'(DEPTH - 1);
  localparam logic [1:0] OP_ADDR = 2'b01, OP_WR = 2'b10, OP_RD = 2'b11;

  typedef enum logic {RELOCK, LOCKED} state_t;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    addr, addr_nxt, rd_val, wr_data;
  logic          is_wr, is_rd, addr_ok, illegal, wr_ok, zero_div, commit, sat_err, err_nxt;
  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          lock_nxt;

  assign is_wr   = (mdopc == OP_WR);
  assign is_rd   = (mdopc == OP_RD);
  assign addr_ok = (int'(addr) < DEPTH);
  assign illegal = ((is_wr || is_rd) && !addr_ok) || (is_wr && (addr == 8'h00 || addr == 8'h05));
  assign wr_ok   = is_wr && !illegal;
  // Dividers must never hold zero; a zero write is coerced to 1 and flagged.
  assign zero_div = wr_ok && (addr == 8'h01 || addr == 8'h02 || addr == 8'h03) && (mdwdi == 8'h00);
  assign commit   = wr_ok && (addr == 8'h04) && mdwdi[0];

  always_comb begin
    rd_val = mem[addr[AW-1:0]];
    if (addr == 8'h00)      rd_val = ID_VALUE;
    else if (addr == 8'h05) rd_val = {6'b0, (state == RELOCK), lock};
  end

  always_comb begin
    wr_data = mdwdi;
    if (zero_div)           wr_data = 8'h01;
    else if (addr == 8'h04) wr_data = {mdwdi[7:1], 1'b0};
  end

  always_comb begin
    addr_nxt = addr;
    sat_err  = 1'b0;
    if (mdopc == OP_ADDR) addr_nxt = mdwdi;
    else if ((is_wr || is_rd) && mdainc) begin
      if (addr == LAST) begin
`ifdef PLL_MD_ADDR_WRAP_EN
        addr_nxt = 8'h00;
`else
        sat_err  = 1'b1;
`endif
      end else begin
        addr_nxt = addr + 8'd1;
      end
    end
  end

  assign err_nxt = illegal || zero_div || sat_err;

  // A commit restarts the relock window from any state; lock follows the state one cycle late.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lock_nxt  = lock;
    if (commit) begin
      state_nxt = RELOCK;
      count_nxt = '0;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        RELOCK: begin
          lock_nxt = 1'b0;
          if (count == CW'(LOCK_CYCLES - 1)) begin
            state_nxt = LOCKED;
            count_nxt = '0;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
        default: lock_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge mdclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RELOCK;
      count <= '0;
      lock  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lock  <= lock_nxt;
    end
  end

  always_ff @(posedge mdclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      mem[1]     <= MULTI_FAC;
      mem[2]     <= DIV0_RST;
      mem[3]     <= DIV2_RST;
      addr       <= 8'h00;
      mdrdo      <= 8'h00;
      cfg_update <= 1'b0;
      md_err     <= 1'b0;
    end else begin
      if (wr_ok) mem[addr[AW-1:0]] <= wr_data;
      if (is_rd) mdrdo <= addr_ok ? rd_val : 8'h00;
      addr       <= addr_nxt;
      cfg_update <= commit;
      md_err     <= err_nxt;
    end
  end

  assign fbdiv = mem[1];
  assign div0  = mem[2];
  assign div2  = mem[3];
endmodule

// File: tb/tb_pll_md_responder.sv
// Directed bench for pll_md_responder: vector table for single-cycle accesses, hand sequences for relock timing.
module tb_pll_md_responder;
  localparam logic [1:0] NOP = 2'b00, ADR = 2'b01, WR = 2'b10, RD = 2'b11;

  logic       mdclk = 1'b0;
  logic       reset_n;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo, fbdiv, div0, div2;
  logic       lock, cfg_update, md_err;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  pll_md_responder dut (
    .mdclk(mdclk), .reset_n(reset_n), .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi),
    .mdrdo(mdrdo), .lock(lock), .fbdiv(fbdiv), .div0(div0), .div2(div2),
    .cfg_update(cfg_update), .md_err(md_err)
  );

  always #5 mdclk = ~mdclk;

  typedef struct {
    logic [1:0] opc;
    logic       ainc;
    logic [7:0] wdi;
    logic [7:0] rdo;
    logic       err;
    logic       upd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] o, logic a, logic [7:0] w, logic [7:0] r, logic e, logic u);
    vec_t v;
    v.opc = o; v.ainc = a; v.wdi = w; v.rdo = r; v.err = e; v.upd = u;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [1:0] o, input logic a, input logic [7:0] w);
    mdopc = o; mdainc = a; mdwdi = w;
    @(negedge mdclk);
    cyc++;
  endtask

  initial begin
    int c0;
    logic saw_lock;

    tbl.push_back(mk(ADR, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'hA5, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'h10, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'h04, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'h08, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(NOP, 0, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h02, 8'h01, 0, 0));
    tbl.push_back(mk(WR,  0, 8'h00, 8'h01, 1, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'hA5, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h05, 8'hA5, 0, 0));
    tbl.push_back(mk(WR,  0, 8'h77, 8'hA5, 1, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h40, 8'h01, 0, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(WR,  0, 8'h12, 8'h00, 1, 0));
    tbl.push_back(mk(ADR, 0, 8'h06, 8'h00, 0, 0));
    tbl.push_back(mk(WR,  1, 8'h3C, 8'h00, 0, 0));
    tbl.push_back(mk(WR,  0, 8'hC3, 8'h00, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h06, 8'h00, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'h3C, 0, 0));
    tbl.push_back(mk(RD,  1, 8'h00, 8'hC3, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h04, 8'hC3, 0, 0));
    tbl.push_back(mk(WR,  0, 8'hFE, 8'hC3, 0, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'hFE, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h01, 8'hFE, 0, 0));
    tbl.push_back(mk(WR,  0, 8'h00, 8'hFE, 1, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'h01, 0, 0));
    tbl.push_back(mk(ADR, 0, 8'h0F, 8'h01, 0, 0));
`ifdef PLL_MD_ADDR_WRAP_EN
    tbl.push_back(mk(WR,  1, 8'h55, 8'h01, 0, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'hA5, 0, 0));
`else
    tbl.push_back(mk(WR,  1, 8'h55, 8'h01, 1, 0));
    tbl.push_back(mk(RD,  0, 8'h00, 8'h55, 0, 0));
`endif

    // Reset state
    reset_n = 1'b0; mdopc = NOP; mdainc = 1'b0; mdwdi = 8'h00;
    @(negedge mdclk);
    @(negedge mdclk);
    chk("rst_mdrdo", 16'(mdrdo), 16'h00);
    chk("rst_lock",  16'(lock), 16'h0);
    chk("rst_fbdiv", 16'(fbdiv), 16'd16);
    chk("rst_div0",  16'(div0), 16'd4);
    chk("rst_div2",  16'(div2), 16'd8);
    chk("rst_pulses", {14'b0, cfg_update, md_err}, 16'h0);

    // Lock after reset release: low through edge 64, high from edge 65
    reset_n = 1'b1;
    saw_lock = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step(NOP, 0, 8'h00);
      if (lock) saw_lock = 1'b1;
    end
    chk("rel_lock_low64", 16'(saw_lock), 16'h0);
    step(NOP, 0, 8'h00);
    chk("rel_lock_at65", 16'(lock), 16'h1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].opc, tbl[i].ainc, tbl[i].wdi);
      chk($sformatf("v%0d_mdrdo", i), 16'(mdrdo), 16'(tbl[i].rdo));
      chk($sformatf("v%0d_md_err", i), 16'(md_err), 16'(tbl[i].err));
      chk($sformatf("v%0d_cfg_update", i), 16'(cfg_update), 16'(tbl[i].upd));
    end
    chk("tbl_fbdiv", 16'(fbdiv), 16'h01);
    chk("tbl_div0",  16'(div0), 16'h01);
    chk("tbl_div2",  16'(div2), 16'h08);

    // Commit from LOCKED
    step(ADR, 0, 8'h01);
    step(WR, 0, 8'h20);
    step(ADR, 0, 8'h04);
    step(WR, 0, 8'h01);
    c0 = cyc;
    chk("c1_update", 16'(cfg_update), 16'h1);
    chk("c1_lock",   16'(lock), 16'h0);
    chk("c1_fbdiv",  16'(fbdiv), 16'h20);
    step(ADR, 0, 8'h05);
    chk("c1_update_clr", 16'(cfg_update), 16'h0);
    step(RD, 0, 8'h00);
    chk("c1_status_busy", 16'(mdrdo), 16'h02);
    saw_lock = 1'b0;
    while (cyc < c0 + 64) begin
      step(NOP, 0, 8'h00);
      if (lock) saw_lock = 1'b1;
    end
    chk("c1_lock_low", 16'(saw_lock), 16'h0);
    step(NOP, 0, 8'h00);
    chk("c1_lock_rise", 16'(lock), 16'h1);
    step(RD, 0, 8'h00);
    chk("c1_status_locked", 16'(mdrdo), 16'h01);

    // Second commit at relock count 30 restarts the window
    step(ADR, 0, 8'h04);
    step(WR, 0, 8'h01);
    c0 = cyc;
    while (cyc < c0 + 30) step(NOP, 0, 8'h00);
    step(WR, 0, 8'h01);
    c0 = cyc;
    chk("c2_update", 16'(cfg_update), 16'h1);
    saw_lock = lock;
    while (cyc < c0 + 64) begin
      step(NOP, 0, 8'h00);
      if (lock) saw_lock = 1'b1;
    end
    chk("c2_lock_low", 16'(saw_lock), 16'h0);
    step(NOP, 0, 8'h00);
    chk("c2_lock_rise", 16'(lock), 16'h1);

    // Reset mid-relock with a write in flight
    step(WR, 0, 8'h01);
    for (int k = 0; k < 5; k++) step(NOP, 0, 8'h00);
    step(ADR, 0, 8'h01);
    step(WR, 0, 8'h77);
    chk("pre_rst_fbdiv", 16'(fbdiv), 16'h77);
    mdopc = WR; mdainc = 1'b0; mdwdi = 8'h99;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_fbdiv", 16'(fbdiv), 16'd16);
    chk("mid_rst_div0",  16'(div0), 16'd4);
    chk("mid_rst_lock",  16'(lock), 16'h0);
    chk("mid_rst_mdrdo", 16'(mdrdo), 16'h00);
    @(negedge mdclk);
    mdopc = NOP;
    reset_n = 1'b1;
    step(RD, 0, 8'h00);
    chk("post_rst_id", 16'(mdrdo), 16'hA5);
    chk("post_rst_fbdiv", 16'(fbdiv), 16'd16);
    step(ADR, 0, 8'h06);
    step(RD, 0, 8'h00);
    chk("post_rst_scratch", 16'(mdrdo), 16'h00);
    step(ADR, 0, 8'h05);
    step(RD, 0, 8'h00);
    chk("post_rst_status", 16'(mdrdo), 16'h02);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
